// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned TUSE_W      = 2;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STALL_CNT_W = 32;

  localparam logic [CNT_W-1:0]  MULT_CYC  = CNT_W'(5);
  localparam logic [CNT_W-1:0]  DIV_CYC   = CNT_W'(10);
  localparam logic [TUSE_W-1:0] TUSE_NONE = TUSE_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // One source operand waits if a younger-needed value is still in flight in E or M; r0 never waits.
  function automatic logic src_stall(
    input logic [REG_W-1:0]  addr,
    input logic [TUSE_W-1:0] tuse,
    input logic [REG_W-1:0]  e_wa,
    input logic [TUSE_W-1:0] e_tnew,
    input logic [REG_W-1:0]  m_wa,
    input logic [TUSE_W-1:0] m_tnew
  );
    return (addr != '0) && (tuse != TUSE_NONE) &&
           (((addr == e_wa) && (e_tnew > tuse)) ||
            ((addr == m_wa) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Mult/div occupancy timer: tracks the fixed-latency unit and flags overlapping starts.
module md_timer
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic err
);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = div ? DIV : MULT;
          cnt_n   = div ? DIV_CYC : MULT_CYC;
        end
      end
      MULT, DIV: begin
        // A start while occupied is dropped; only the sticky error records it.
        if (start) err_n = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard detection: data and mult/div stalls, plus a saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       D_rs_addr,
  input  logic [REG_W-1:0]       D_rt_addr,
  input  logic [TUSE_W-1:0]      D_tuse_rs,
  input  logic [TUSE_W-1:0]      D_tuse_rt,
  input  logic [REG_W-1:0]       E_wa,
  input  logic [REG_W-1:0]       M_wa,
  input  logic [TUSE_W-1:0]      E_tnew,
  input  logic [TUSE_W-1:0]      M_tnew,
  input  logic                   D_md,
  input  logic                   E_md_start,
  input  logic                   E_md_div,
  output logic                   stall_F,
  output logic                   stall_D,
  output logic                   flush_E,
  output logic                   md_busy,
  output logic                   md_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic stall_rs, stall_rt, stall_md, stall;

  md_timer u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (E_md_start),
    .div   (E_md_div),
    .busy  (md_busy),
    .err   (md_err)
  );

  always_comb begin
    stall_rs = src_stall(D_rs_addr, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
    stall_rt = src_stall(D_rt_addr, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
    stall_md = D_md && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: data hazards, mult/div timing, reset abort, counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md, E_md_start, E_md_div;
  logic        stall_F, stall_D, flush_E, md_busy, md_err;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .E_wa       (E_wa),
    .M_wa       (M_wa),
    .E_tnew     (E_tnew),
    .M_tnew     (M_tnew),
    .D_md       (D_md),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_E    (flush_E),
    .md_busy    (md_busy),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_F"}, 32'(stall_F), 32'(exp));
    chk({tag, "_D"}, 32'(stall_D), 32'(exp));
    chk({tag, "_E"}, 32'(flush_E), 32'(exp));
  endtask

  task automatic clear_data();
    D_rs_addr = '0; D_rt_addr = '0; E_wa = '0; M_wa = '0;
    D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; E_tnew = '0; M_tnew = '0;
  endtask

  // Inputs change just after the falling edge; checks run 1ns later, well before the rising edge.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    clear_data();
    D_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;

    // Reset state; stall logic stays combinational while held in reset.
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_err", 32'(md_err), 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk_stall("rst_idle", 1'b0);
    next();
    D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd1;
    #1 chk_stall("rst_follow", 1'b1);
    next();
    #1 chk("rst_cnt_hold", stall_cnt, 32'd0);
    clear_data();
    reset = 1'b1;

    // E-stage rs hazard, then resolved.
    next();
    D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd1;
    #1 chk_stall("e_rs_haz", 1'b1);
    next();
    E_tnew = 2'd0;
    #1 chk_stall("e_rs_ok", 1'b0);
    chk("cnt_1", stall_cnt, 32'd1);

    // M-stage rt hazard, then enough slack, then operand unused.
    next();
    clear_data();
    D_rt_addr = 5'd7; D_tuse_rt = 2'd1; M_wa = 5'd7; M_tnew = 2'd2;
    #1 chk_stall("m_rt_haz", 1'b1);
    next();
    D_tuse_rt = 2'd2;
    #1 chk_stall("m_rt_ok", 1'b0);
    chk("cnt_2", stall_cnt, 32'd2);
    D_tuse_rt = 2'd3;
    #1 chk_stall("m_rt_none", 1'b0);

    // Register 0 never stalls.
    next();
    clear_data();
    D_rt_addr = 5'd0; D_tuse_rt = 2'd0; E_wa = 5'd0; E_tnew = 2'd2;
    D_rs_addr = 5'd0; D_tuse_rs = 2'd0; M_wa = 5'd0; M_tnew = 2'd2;
    #1 chk_stall("r0", 1'b0);
    next();
    clear_data();

    // Mult: busy for exactly 5 cycles; D_md stalls start cycle plus those 5.
    D_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
    #1 chk_stall("mul_start", 1'b1);
    chk("mul_start_busy", 32'(md_busy), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      next();
      E_md_start = 1'b0;
      #1 chk($sformatf("mul_busy%0d", i), 32'(md_busy), 32'd1);
      chk_stall($sformatf("mul_stall%0d", i), 1'b1);
    end
    next();
    #1 chk("mul_done", 32'(md_busy), 32'd0);
    chk_stall("mul_release", 1'b0);
    chk("cnt_8", stall_cnt, 32'd8);
    chk("mul_err", 32'(md_err), 32'd0);
    D_md = 1'b0;

    // Div with an overlapping start at busy cycle 3: sticky error, latency unchanged.
    next();
    E_md_start = 1'b1; E_md_div = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      next();
      E_md_start = (i == 3);
      E_md_div   = 1'b0;
      #1 chk($sformatf("div_busy%0d", i), 32'(md_busy), 32'd1);
      if (i >= 4) chk($sformatf("div_err%0d", i), 32'(md_err), 32'd1);
    end
    next();
    #1 chk("div_done", 32'(md_busy), 32'd0);
    chk("div_err_sticky", 32'(md_err), 32'd1);
    next();
    #1 chk("div_still_idle", 32'(md_busy), 32'd0);
    chk("cnt_still_8", stall_cnt, 32'd8);

    // Div aborted by reset at busy cycle 4.
    E_md_start = 1'b1; E_md_div = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      next();
      E_md_start = 1'b0;
    end
    #1 chk("abort_busy_pre", 32'(md_busy), 32'd1);
    reset = 1'b0;
    #1 chk("abort_busy", 32'(md_busy), 32'd0);
    chk("abort_err", 32'(md_err), 32'd0);
    chk("abort_cnt", stall_cnt, 32'd0);
    next();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      next();
      #1 chk($sformatf("abort_idle%0d", i), 32'(md_busy), 32'd0);
    end
    chk("abort_cnt_after", stall_cnt, 32'd0);

    // Counter saturation.
    next();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd1;
    #1 chk("sat_pre", stall_cnt, 32'hFFFF_FFFE);
    for (int i = 1; i <= 3; i++) begin
      next();
      #1 chk($sformatf("sat%0d", i), stall_cnt, 32'hFFFF_FFFF);
    end
    clear_data();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have reset, input, 1, asynchronous and active-low; reset low clears all state immediately.
REQ-003 SHALL have D_rs_addr and D_rt_addr, input, 5 each, source registers of the instruction held in the D pipeline register.
REQ-004 SHALL have D_tuse_rs and D_tuse_rt, input, 2 each, cycles until D needs rs/rt; 3 = not used.
REQ-005 SHALL have E_wa and M_wa, input, 5 each, destination registers in E and M; 0 = none.
REQ-006 SHALL have E_tnew and M_tnew, input, 2 each, cycles until the E/M result is available.
REQ-007 SHALL have D_md, input, 1, D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have E_md_start and E_md_div, input, 1 each: E starts a mult/div op; 1 = div, 0 = mult.
REQ-009 SHALL have stall_F and stall_D, output, 1 each, hold-enables for PC and the D pipeline register.
REQ-010 SHALL have flush_E, output, 1, which loads a bubble (nop, pc retained) into E.
REQ-011 SHALL have md_busy, output, 1, mult/div unit occupied.
REQ-012 SHALL have md_err, output, 1, sticky flag: a start arrived while busy.
REQ-013 SHALL have stall_cnt, output, 32, count of stalled cycles.

Function
REQ-014 SHALL compute data stall_rs = (D_rs_addr!=0) && ((D_rs_addr==E_wa && E_tnew>D_tuse_rs) || (D_rs_addr==M_wa && M_tnew>D_tuse_rs)); stall_rt is the same using rt.
REQ-015 SHALL compute md stall = D_md && (md_busy || E_md_start).
REQ-016 SHALL drive stall = stall_rs || stall_rt || md stall, combinationally in the same cycle, with stall_F = stall_D = flush_E = stall.
REQ-017 SHALL implement an FSM with states IDLE, MULT and DIV, plus a 4-bit down-counter cnt.
REQ-018 In IDLE, E_md_start SHALL move the FSM to DIV with cnt=10 when E_md_div=1, or to MULT with cnt=5 when E_md_div=0.
REQ-019 In MULT/DIV, cnt SHALL decrement each cycle; when cnt==1 the next state SHALL be IDLE with cnt=0.
REQ-020 SHALL drive md_busy = (state!=IDLE), registered, so it is asserted for exactly 5 (mult) or 10 (div) cycles starting the cycle after the start edge.
REQ-021 If E_md_start arrives while not IDLE, it SHALL be ignored, the counter SHALL be unaffected, and md_err SHALL set and stay set until reset.
REQ-022 On the cycle cnt==1, md_busy SHALL still be 1; a D_md instruction SHALL stall that cycle and be released the next.
REQ-023 stall_cnt SHALL increment by 1 on each clock edge where stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-024 Register 0 SHALL never cause a data stall, even if E_wa==0 with a large E_tnew.

Reset
REQ-025 While reset=0, the block SHALL set state=IDLE, cnt=0, md_busy=0, md_err=0 and stall_cnt=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abort the current op, with no residual busy after release.
REQ-027 Stall outputs SHALL remain combinational during reset and follow the inputs, with md_busy=0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the latency constants MULT_CYC=5 and DIV_CYC=10, and the TUSE_NONE=3 encoding.
REQ-029 One sub-module, md_timer, SHALL contain the FSM and counter and output md_busy/md_err; the stall logic and stall_cnt SHALL stay in hazard_ctrl.

Verification
REQ-030 D_rs=5, D_tuse_rs=0, E_wa=5, E_tnew=1 -> stall_F=stall_D=flush_E=1; then E_tnew=0 -> all three 0.
REQ-031 D_rt=0, E_wa=0, E_tnew=2, D_tuse_rt=0 -> stall=0.
REQ-032 E_md_start=1, E_md_div=0 for 1 cycle -> md_busy=1 for exactly 5 cycles; D_md=1 throughout -> stall for the start cycle plus those 5 cycles, then stall=0.
REQ-033 Div start, then reset low at busy cycle 4 -> md_busy=0 at once; after release, no busy and stall_cnt=0.
REQ-034 Div start, then a second E_md_start at busy cycle 3 -> md_err=1 persistently, and md_busy still drops after exactly 10 cycles.
REQ-035 stall_cnt forced to near 32'hFFFF_FFFE, then 3 stall cycles -> stall_cnt holds at 32'hFFFF_FFFF.
